// File: rtl/seq_scan_arbiter_if.sv
// Requester-side bus of the scan arbiter: request/data in, grant and result out.
interface seq_scan_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 8,
    parameter int CW   = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              ser_bit;
    logic              det_hit;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic [CW-1:0]     match_cnt;

    modport master (
        output req, data,
        input  gnt, busy, ser_bit, det_hit, done, done_id, match_cnt
    );

    modport slave (
        input  req, data,
        output gnt, busy, ser_bit, det_hit, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter feeding one shared overlapping "101" Mealy detector.
// The granted word is shifted out MSB-first; hits are counted and reported
// with the requester ID one cycle after the scan finishes.
module seq_scan_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 8,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_scan_arbiter_if.slave  bus
);
    localparam int BCW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} state_t;
    typedef enum logic [1:0] {D_S0 = 2'd0, D_S1 = 2'd1, D_S10 = 2'd2} det_t;

    state_t          state_q, state_d;
    det_t            det_q, det_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [BCW-1:0]  bitcnt_q, bitcnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            arb_found;
    logic [IDW-1:0]  arb_idx;
    logic [W-1:0]    arb_data;
    logic            ser;
    logic            hit;
    det_t            det_nxt;

    // Round-robin pick: first set request at or after the pointer, wrapping.
    always_comb begin : arb_p
        logic [IDW:0] j;
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, ptr_q} + (IDW+1)'(k);
            if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
            if (!arb_found && bus.req[j[IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = j[IDW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == arb_idx) arb_data = bus.data[i*W +: W];
        end
    end

    // Mealy detector: next state and hit for the bit on the wire this cycle.
    always_comb begin
        ser     = (state_q == SHIFT) & shreg_q[W-1];
        det_nxt = D_S0;
        hit     = 1'b0;
        case (det_q)
            D_S0:    det_nxt = ser ? D_S1 : D_S0;
            D_S1:    det_nxt = ser ? D_S1 : D_S10;
            D_S10: begin
                det_nxt = ser ? D_S1 : D_S0;
                hit     = ser & (state_q == SHIFT);
            end
            default: det_nxt = D_S0;
        endcase
    end

    // Scan FSM: grant, shift, report.
    always_comb begin
        state_d   = state_q;
        det_d     = det_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    shreg_d  = arb_data;
                    win_d    = arb_idx;
                    gnt_d    = NREQ'(1) << arb_idx;
                    det_d    = D_S0;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                det_d    = det_nxt;
                if (hit) cnt_d = cnt_q + 1'b1;
                if (bitcnt_q == BCW'(W-1)) state_d = REPORT;
            end
            REPORT: begin
                done_d    = 1'b1;
                done_id_d = win_q;
                ptr_d     = (win_q == IDW'(NREQ-1)) ? '0 : win_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any scan in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            det_q     <= D_S0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            det_q     <= det_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ser_bit   = ser;
    assign bus.det_hit   = hit;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/results, a monitor pops and compares.
module tb_seq_scan_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 8;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_scan_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .W(W), .CW(CW)) bus ();

    seq_scan_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [CW-1:0]  cnt;
    } res_t;

    logic [NREQ-1:0] exp_gnt_q [$];
    res_t            exp_res_q [$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int gnt_cyc = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every grant and every done against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.gnt != '0) begin
                if (exp_gnt_q.size() == 0) chk("unexpected_gnt", int'(bus.gnt), 0);
                else chk("gnt", int'(bus.gnt), int'(exp_gnt_q.pop_front()));
                gnt_cyc = cyc;
            end
            if (bus.done) begin
                res_t r;
                chk("done_latency", cyc - gnt_cyc, W + 1);
                if (exp_res_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    r = exp_res_q.pop_front();
                    chk("done_id", int'(bus.done_id), int'(r.id));
                    chk("match_cnt", int'(bus.match_cnt), int'(r.cnt));
                end
            end
            if (!bus.busy && bus.det_hit) chk("det_hit_idle", 1, 0);
        end
    end

    task automatic set_word(input int i, input logic [W-1:0] w);
        bus.data[i*W +: W] = w;
    endtask

    task automatic expect_scan(input int id, input int cnt);
        res_t r;
        r.id  = IDW'(id);
        r.cnt = CW'(cnt);
        exp_gnt_q.push_back(NREQ'(1) << id);
        exp_res_q.push_back(r);
    endtask

    // Raise the masked requests, drop each after its grant (scrambling its
    // data to show it is not resampled), then wait for the block to go idle.
    task automatic scan(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        int n;
        pend = mask;
        bus.req = bus.req | mask;
        n = 0;
        while (pend != '0 && n < 400) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i]) bus.data[i*W +: W] = ~bus.data[i*W +: W];
            end
            pend    = pend & ~bus.gnt;
            bus.req = bus.req & ~bus.gnt;
        end
        if (pend != '0) chk("grant_timeout", int'(pend), 0);
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("busy_timeout", 1, 0);
    endtask

    initial begin
        int bad;
        int n;
        bus.req  = '0;
        bus.data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_done_id", int'(bus.done_id), 0);
        chk("rst_match_cnt", int'(bus.match_cnt), 0);
        chk("rst_ser_bit", int'(bus.ser_bit), 0);
        chk("rst_det_hit", int'(bus.det_hit), 0);
        rst = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy || bus.gnt != '0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Alternating word: three overlapping hits.
        set_word(0, 8'b10101010); expect_scan(0, 3); scan(4'b0001);
        // All ones: none; 10110101: three with overlap.
        set_word(0, 8'b11111111); expect_scan(0, 0); scan(4'b0001);
        set_word(0, 8'b10110101); expect_scan(0, 3); scan(4'b0001);
        // Pending "10" at word end must not combine with the next word's leading 1.
        set_word(2, 8'b00000010); expect_scan(2, 0); scan(4'b0100);
        set_word(3, 8'b10000000); expect_scan(3, 0); scan(4'b1000);
        // Pointer is back at 0: all four requests serve in order.
        set_word(0, 8'b10101010);
        set_word(1, 8'b11111111);
        set_word(2, 8'b10110101);
        set_word(3, 8'b00000010);
        expect_scan(0, 3); expect_scan(1, 0); expect_scan(2, 3); expect_scan(3, 0);
        scan(4'b1111);

        // Move the pointer to 2, then abort a scan of req[2] mid-shift.
        set_word(1, 8'b10101010); expect_scan(1, 3); scan(4'b0010);
        set_word(2, 8'b10101010);
        exp_gnt_q.push_back(4'b0100);
        bus.req = 4'b0100;
        n = 0;
        while (bus.gnt == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_gnt_seen", int'(bus.gnt), 4);
        bus.req = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) bad++;
        end
        chk("abort_no_done", bad, 0);

        // Pointer reset: req[0] beats req[2].
        set_word(0, 8'b10110101);
        set_word(2, 8'b11111111);
        expect_scan(0, 3); expect_scan(2, 0);
        scan(4'b0101);

        repeat (3) @(negedge clk);
        chk("gnt_queue_empty", exp_gnt_q.size(), 0);
        chk("res_queue_empty", exp_res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
